throttle_sched: RTL and testbench
=================================

# throttle_sched

Frequency-select scheduler for the throttle clock path. It arbitrates between manual step requests and a host target-load request, and sequences the select one step at a time with a programmable dwell between steps. It also generates the divided clock enable (`tick`) from its own free-running counter. Debounced single-cycle pushbutton pulses come in; the step clock enable and the current select go out to the downstream stepper or display logic.

## Interface

- `SEL_MAX`, 5: highest legal select value; select 0 is the slowest rate.
- `CNT_W`, 26: width of the free-running divider counter.
- `TOP_BIT`, 25: tick bit for select 0. Requires `TOP_BIT - SEL_MAX >= 0` and `TOP_BIT < CNT_W`.
- `DWELL`, 50000000: cycles between ramp steps, and manual lockout length. Must be at least 1.
- `DWELL_W`, 26: dwell counter width. Must satisfy `2^DWELL_W > DWELL - 1`.

- `CLK_50`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pb_up_pulse`  in  1  debounced one-cycle request: step select up.
- `pb_dn_pulse`  in  1  debounced one-cycle request: step select down.
- `load_valid`  in  1  host target request; held until accepted.
- `load_target`  in  3  requested select value; must be stable while `load_valid` is high.
- `load_ready`  out  1  high when the state is IDLE.
- `freq_sel`  out  3  current select, registered.
- `tick`  out  1  one-cycle rate enable for the current select.
- `busy`  out  1  high when the state is not IDLE.
- `ramp_done`  out  1  one-cycle pulse when a host load completes.

## Operation

- **State machine:** IDLE, RAMP, HOLD. The dwell counter is `DWELL_W` bits wide.
- **IDLE, host load:** if `load_valid` is high, the load is accepted. The target is clamped: T = min(`load_target`, `SEL_MAX`).
  - If T == `freq_sel`: stay in IDLE; `ramp_done` goes high for the next cycle.
  - Otherwise: go to RAMP and load the dwell counter with `DWELL-1`.
- **IDLE, manual step:** applies only when `load_valid` is low; host load has priority.
  - An `up` pulse alone with `freq_sel < SEL_MAX`, or a `dn` pulse alone with `freq_sel > 0`: `freq_sel` moves ±1, the state goes to HOLD, and the dwell counter loads `DWELL-1`.
  - A pulse at the saturation bound is ignored completely: no change and no HOLD.
  - `up` and `dn` in the same cycle are ignored.
- **RAMP:**
  - When the dwell counter is nonzero, it decrements.
  - When it reaches 0, `freq_sel` moves one step toward T and the counter reloads `DWELL-1`.
  - On the step that reaches T: go to IDLE and assert `ramp_done` for the next cycle.
  - Manual pulses are dropped, not queued.
- **HOLD:** the dwell counter decrements and the block returns to IDLE when it reaches 0. Manual pulses and host loads are not accepted; `load_ready` is 0.
- **Divider:** `count` (`CNT_W` bits) increments every cycle and wraps naturally at 2^`CNT_W`.
  - `tick` = 1 when `count[TOP_BIT - freq_sel : 0]` is all ones.
  - Tick period is 2^(`TOP_BIT` - `freq_sel` + 1) cycles.
  - `tick` is decoded combinationally from registered `count` and `freq_sel`, so it is glitch-free per cycle.
  - A select change does not reset `count`. The first tick at the new rate follows the next all-ones match.
- **Reset:** `freq_sel`=0, state IDLE, dwell counter 0, `count`=0, `ramp_done`=0, `tick`=0, `busy`=0, `load_ready`=1.
  - Reset in the middle of a ramp or hold aborts it; no `ramp_done` is produced.

## Timing

- Host load accepted at edge k with distance N = |T - S|: `freq_sel` changes at edges k+D, k+2D, … , k+N·D.
- `ramp_done` is high during the cycle after edge k+N·D; `busy` falls at that same edge.
- Manual pulse sampled at edge k: `freq_sel` updates at k (visible in cycle k+1). HOLD lasts until edge k+D, and the next pulse is accepted from edge k+D+1 onward.
- `load_ready` and `busy` are decoded from the state register. There is no combinational path from any input to any output.
- The handshake completes on a cycle where both `load_valid` and `load_ready` are high. The host drops `load_valid` after that edge.

## Test plan

Parameters for all scenarios: `TOP_BIT`=6, `CNT_W`=8, `DWELL`=4, `SEL_MAX`=5.

1. **Reset release:** `freq_sel`=0, `load_ready`=1. `tick` is high when `count`=127 and 255, a period of 128. `busy` stays 0.
2. **Ramp up:** load T=3 at edge k → `freq_sel` is 1 at k+4, 2 at k+8, 3 at k+12. `ramp_done` pulses once, `busy` falls at k+12. `tick` period becomes 16.
3. **Clamp and override:** load T=7 → ramps to 5, tick period 4. During the ramp, `up`/`dn` pulses are ignored and `load_ready` stays 0.
4. **Manual stepping:** `up` at sel 0 → 1. A second `up` 2 cycles later is ignored. An `up` 5 cycles after the first → 2. Simultaneous `up`+`dn` → no change. `dn` at sel 0 → no change, `busy` stays 0.
5. **Load equal to current:** at sel 2, load T=2 → accepted in one cycle, `ramp_done` pulses, no RAMP. Ramp down 5→1 takes 16 cycles.
6. **Reset mid-ramp:** reset asserted while ramping 2→5 → `freq_sel`=0, `busy`=0 immediately, no `ramp_done`. After release, load T=1 completes in 4 cycles.

Source files
------------

// File: rtl/throttle_sched.sv
// Frequency-select scheduler: arbitrates manual step pulses against host target loads,
// walks freq_sel one step per dwell period, and decodes the divided clock enable.
module throttle_sched #(
    parameter int SEL_MAX = 5,
    parameter int CNT_W   = 26,
    parameter int TOP_BIT = 25,
    parameter int DWELL   = 50000000,
    parameter int DWELL_W = 26
) (
    input  logic       CLK_50,
    input  logic       reset,
    input  logic       pb_up_pulse,
    input  logic       pb_dn_pulse,
    input  logic       load_valid,
    input  logic [2:0] load_target,
    output logic       load_ready,
    output logic [2:0] freq_sel,
    output logic       tick,
    output logic       busy,
    output logic       ramp_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RAMP,
        S_HOLD
    } state_t;

    localparam logic [2:0]         SEL_TOP      = 3'(SEL_MAX);
    localparam logic [DWELL_W-1:0] DWELL_RELOAD = DWELL_W'(DWELL - 1);

    state_t             r_state;
    logic [2:0]         r_sel;
    logic [2:0]         r_target;
    logic [DWELL_W-1:0] r_dwell;
    logic [CNT_W-1:0]   r_count;
    logic               r_ramp_done;

    logic [2:0]         w_target;
    logic [2:0]         w_step;
    logic [CNT_W-1:0]   w_mask;

    assign w_target = (load_target > SEL_TOP) ? SEL_TOP : load_target;
    assign w_step   = (r_target > r_sel) ? r_sel + 3'd1 : r_sel - 3'd1;

    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sel       <= '0;
            r_target    <= '0;
            r_dwell     <= '0;
            r_ramp_done <= 1'b0;
        end else begin
            r_ramp_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load_valid) begin
                        r_target <= w_target;
                        if (w_target == r_sel) begin
                            r_ramp_done <= 1'b1;
                        end else begin
                            r_state <= S_RAMP;
                            r_dwell <= DWELL_RELOAD;
                        end
                    end else if (pb_up_pulse && !pb_dn_pulse && r_sel < SEL_TOP) begin
                        r_sel   <= r_sel + 3'd1;
                        r_state <= S_HOLD;
                        r_dwell <= DWELL_RELOAD;
                    end else if (pb_dn_pulse && !pb_up_pulse && r_sel != 3'd0) begin
                        r_sel   <= r_sel - 3'd1;
                        r_state <= S_HOLD;
                        r_dwell <= DWELL_RELOAD;
                    end
                end
                S_RAMP: begin
                    if (r_dwell != '0) begin
                        r_dwell <= r_dwell - DWELL_W'(1);
                    end else begin
                        r_sel <= w_step;
                        if (w_step == r_target) begin
                            r_state     <= S_IDLE;
                            r_ramp_done <= 1'b1;
                        end else begin
                            r_dwell <= DWELL_RELOAD;
                        end
                    end
                end
                S_HOLD: begin
                    if (r_dwell != '0) begin
                        r_dwell <= r_dwell - DWELL_W'(1);
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Bits [TOP_BIT-freq_sel:0] of the counter must all be ones for a tick.
    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < CNT_W; i++) begin
            if (i + 32'(r_sel) <= 32'(TOP_BIT)) begin
                w_mask[i] = 1'b1;
            end
        end
    end

    assign tick       = &(r_count | ~w_mask);
    assign freq_sel   = r_sel;
    assign ramp_done  = r_ramp_done;
    assign busy       = (r_state != S_IDLE);
    assign load_ready = (r_state == S_IDLE);

endmodule

// File: tb/tb_throttle_sched.sv
// Randomized scoreboard bench for throttle_sched: the driver predicts freq_sel/ramp_done
// events from the scheduling rules; a negedge monitor pops and checks them as they appear.
module tb_throttle_sched;

    localparam int unsigned D      = 4;
    localparam int unsigned SMAX   = 5;
    localparam int unsigned TOPB   = 6;

    typedef struct {
        int unsigned e;
        logic [2:0]  s;
        bit          d;
    } ev_t;

    logic       CLK_50 = 1'b0;
    logic       reset;
    logic       pb_up_pulse, pb_dn_pulse, load_valid;
    logic [2:0] load_target;
    logic       load_ready, tick, busy, ramp_done;
    logic [2:0] freq_sel;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned edge_n  = 0;
    bit          run_mon = 1'b0;

    ev_t         q[$];
    logic [2:0]  m_sel = 3'd0;
    int unsigned free_at = 0;
    int unsigned bs = 0, be = 0;
    logic [2:0]  mon_sel = 3'd0;
    logic [2:0]  last_sel = 3'd0;

    throttle_sched #(
        .SEL_MAX(5),
        .CNT_W  (8),
        .TOP_BIT(6),
        .DWELL  (4),
        .DWELL_W(4)
    ) dut (
        .CLK_50     (CLK_50),
        .reset      (reset),
        .pb_up_pulse(pb_up_pulse),
        .pb_dn_pulse(pb_dn_pulse),
        .load_valid (load_valid),
        .load_target(load_target),
        .load_ready (load_ready),
        .freq_sel   (freq_sel),
        .tick       (tick),
        .busy       (busy),
        .ramp_done  (ramp_done)
    );

    always #5 CLK_50 = ~CLK_50;

    always @(posedge CLK_50) begin
        if (reset) edge_n = 0;
        else       edge_n = edge_n + 1;
    end

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    // Monitor: an output event is a change of freq_sel or a ramp_done pulse.
    always @(negedge CLK_50) begin
        if (run_mon && !reset) begin
            if (freq_sel !== last_sel || ramp_done !== 1'b0) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_event: got sel=%0d done=%0d expected none (edge %0d)",
                             freq_sel, ramp_done, edge_n);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    check("event_edge", int'(edge_n), int'(e.e));
                    check("event_sel", int'(freq_sel), int'(e.s));
                    check("event_done", int'(ramp_done), int'(e.d));
                    mon_sel = e.s;
                end
                last_sel = freq_sel;
            end
            begin
                int unsigned mask;
                bit          bexp;
                mask = (32'd1 << (TOPB + 1 - int'(mon_sel))) - 1;
                check("tick", int'(tick), int'((edge_n & mask) == mask));
                bexp = (edge_n >= bs) && (edge_n < be);
                check("busy", int'(busy), int'(bexp));
                check("load_ready", int'(load_ready), int'(!bexp));
            end
        end
    end

    task automatic push_ev(input int unsigned e, input int unsigned s, input bit d);
        ev_t ev;
        ev.e = e;
        ev.s = 3'(s);
        ev.d = d;
        q.push_back(ev);
    endtask

    // Host load: valid is held until the model says the block is IDLE at the sampling edge.
    task automatic do_load(input logic [2:0] tgt);
        int unsigned ka, t, s, n;
        load_valid  = 1'b1;
        load_target = tgt;
        while (edge_n + 1 < free_at) @(negedge CLK_50);
        ka = edge_n + 1;
        t  = (int'(tgt) > SMAX) ? SMAX : int'(tgt);
        s  = int'(m_sel);
        if (t == s) begin
            push_ev(ka, s, 1'b1);
            free_at = ka + 1;
        end else begin
            n = (t > s) ? t - s : s - t;
            for (int unsigned i = 1; i <= n; i++)
                push_ev(ka + i * D, (t > s) ? s + i : s - i, i == n);
            bs      = ka;
            be      = ka + n * D;
            free_at = be + 1;
            m_sel   = 3'(t);
        end
        @(negedge CLK_50);
        load_valid  = 1'b0;
        load_target = 3'd0;
    endtask

    task automatic do_pulse(input bit up, input bit dn);
        int unsigned k;
        k = edge_n + 1;
        pb_up_pulse = up;
        pb_dn_pulse = dn;
        if (k >= free_at && (up ^ dn)) begin
            if (up && int'(m_sel) < SMAX) begin
                m_sel = m_sel + 3'd1;
                push_ev(k, int'(m_sel), 1'b0);
                bs = k; be = k + D; free_at = be + 1;
            end else if (dn && m_sel != 3'd0) begin
                m_sel = m_sel - 3'd1;
                push_ev(k, int'(m_sel), 1'b0);
                bs = k; be = k + D; free_at = be + 1;
            end
        end
        @(negedge CLK_50);
        pb_up_pulse = 1'b0;
        pb_dn_pulse = 1'b0;
    endtask

    task automatic random_ops(input int unsigned cnt);
        for (int unsigned i = 0; i < cnt; i++) begin
            int unsigned op;
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: do_pulse(1'b1, 1'b0);
                3, 4:    do_pulse(1'b0, 1'b1);
                5:       do_pulse(1'b1, 1'b1);
                6:       do_load(3'($urandom_range(0, 7)));
                default: repeat ($urandom_range(1, 3)) @(negedge CLK_50);
            endcase
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        pb_up_pulse = 1'b0;
        pb_dn_pulse = 1'b0;
        load_valid  = 1'b0;
        load_target = 3'd0;
        repeat (3) @(negedge CLK_50);
        check("rst_sel", int'(freq_sel), 0);
        check("rst_ready", int'(load_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_done", int'(ramp_done), 0);
        reset   = 1'b0;
        run_mon = 1'b1;

        // Idle long enough to see the select-0 tick at count 127 and 255.
        repeat (260) @(negedge CLK_50);
        do_load(3'd3);
        do_load(3'd7);
        do_pulse(1'b1, 1'b0);
        do_load(3'd1);
        random_ops(700);

        // Abort a ramp with reset; no ramp_done may follow.
        do_load(3'd2);
        do_load(3'd5);
        repeat (6) @(negedge CLK_50);
        run_mon = 1'b0;
        reset   = 1'b1;
        #1;
        check("midrst_sel", int'(freq_sel), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_ready", int'(load_ready), 1);
        check("midrst_done", int'(ramp_done), 0);
        q.delete();
        m_sel = 3'd0; mon_sel = 3'd0; last_sel = 3'd0;
        free_at = 0; bs = 0; be = 0;
        @(negedge CLK_50);
        @(negedge CLK_50);
        reset   = 1'b0;
        run_mon = 1'b1;
        do_load(3'd1);
        random_ops(300);

        begin
            int unsigned guard;
            guard = 0;
            while ((q.size() != 0 || edge_n < free_at) && guard < 200) begin
                @(negedge CLK_50);
                guard++;
            end
        end
        check("drain_pending", int'(q.size()), 0);
        @(negedge CLK_50);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
